masked_round_state_reg: RTL and testbench



---
 rtl/masked_round_state_reg_pkg.sv | 25 ++
 rtl/masked_round_state_reg_share_reg_bank.sv | 30 +++
 rtl/masked_round_state_reg.sv | 116 +++++++++++
 tb/tb_masked_round_state_reg.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/masked_round_state_reg_pkg.sv
// Shared definitions for the masked round state register: FSM encoding,
// a constant-friendly ceil(log2) helper and the share-slice offset helper.
package masked_round_state_reg_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fsm_state_e;

    // ceil(log2(value)); returns 0 for value <= 1. Usable in parameter context.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 32'd0;
        while ((64'd1 << res) < 64'(value)) begin
            res = res + 32'd1;
        end
        return res;
    endfunction

    // Lowest bit index of share idx inside a packed share bus.
    function automatic int unsigned share_lsb(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/masked_round_state_reg_share_reg_bank.sv
// One share of the cipher state: a WIDTH-bit register fed by a D0/D1 mux.
// Deliberately free of control logic so every share sees identical timing.
module share_reg_bank #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sel,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_r;

    // State flop: clear on reset, otherwise load the selected source when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= '0;
        end else if (en) begin
            q_r <= sel ? d1 : d0;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/masked_round_state_reg.sv
// Share-aware cipher state register with round/stage sequencing. Loads the
// masked plaintext on start, then captures the round-function output every
// STAGES cycles for ROUNDS rounds and pulses done on the last capture.
module masked_round_state_reg
    import masked_round_state_reg_pkg::*;
#(
    parameter  int unsigned WIDTH  = 64,
    parameter  int unsigned SHARES = 2,
    parameter  int unsigned ROUNDS = 40,
    parameter  int unsigned STAGES = 4,
    localparam int unsigned RW     = clog2(ROUNDS + 32'd1),
    localparam int unsigned SW     = (STAGES > 32'd1) ? clog2(STAGES) : 32'd1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [WIDTH*SHARES-1:0]  D0,
    input  logic [WIDTH*SHARES-1:0]  D1,
    output logic [WIDTH*SHARES-1:0]  Q,
    output logic [RW-1:0]            round,
    output logic [SW-1:0]            stage,
    output logic                     busy,
    output logic                     done
);

    localparam logic [SW-1:0] LAST_STAGE = SW'(STAGES - 32'd1);
    localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 32'd1);

    fsm_state_e    state_r, state_nx_s;
    logic [RW-1:0] round_r, round_nx_s;
    logic [SW-1:0] stage_r, stage_nx_s;
    logic          busy_r;
    logic          done_r, done_nx_s;
    logic          load_en_s;
    logic          load_sel_s;

    // Next-state logic: sequencing of load, stage counting and round capture.
    always_comb begin
        state_nx_s = state_r;
        round_nx_s = round_r;
        stage_nx_s = stage_r;
        done_nx_s  = 1'b0;
        load_en_s  = 1'b0;
        load_sel_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    load_en_s  = 1'b1;
                    load_sel_s = 1'b0;
                    round_nx_s = '0;
                    stage_nx_s = '0;
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stage_r == LAST_STAGE) begin
                    load_en_s  = 1'b1;
                    load_sel_s = 1'b1;
                    stage_nx_s = '0;
                    round_nx_s = round_r + RW'(1);
                    if (round_r == LAST_ROUND) begin
                        done_nx_s  = 1'b1;
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end else begin
                    stage_nx_s = stage_r + SW'(1);
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Control registers; reset abandons any run in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            round_r <= '0;
            stage_r <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            round_r <= round_nx_s;
            stage_r <= stage_nx_s;
            busy_r  <= (state_nx_s == ST_RUN);
            done_r  <= done_nx_s;
        end
    end

    // One bank per share; each slice only ever sees its own slice of D0/D1.
    for (genvar i = 0; i < SHARES; i++) begin : g_share
        share_reg_bank #(
            .WIDTH (WIDTH)
        ) u_bank (
            .clk (clk),
            .rst (rst),
            .en  (load_en_s),
            .sel (load_sel_s),
            .d0  (D0[share_lsb(i, WIDTH) +: WIDTH]),
            .d1  (D1[share_lsb(i, WIDTH) +: WIDTH]),
            .q   (Q[share_lsb(i, WIDTH) +: WIDTH])
        );
    end

    assign round = round_r;
    assign stage = stage_r;
    assign busy  = busy_r;
    assign done  = done_r;

endmodule

// File: tb/tb_masked_round_state_reg.sv
// Directed self-checking bench for masked_round_state_reg: a WIDTH=8,
// SHARES=2, ROUNDS=3, STAGES=4 instance plus a STAGES=1, ROUNDS=5 instance.
module tb_masked_round_state_reg;

    logic        clk;
    logic        rst, start;
    logic [15:0] d0, d1, q;
    logic [1:0]  round;
    logic [1:0]  stage;
    logic        busy, done;

    logic        rst2, start2;
    logic [15:0] d0_2, d1_2, q2;
    logic [2:0]  round2;
    logic [0:0]  stage2;
    logic        busy2, done2;

    int total = 0;
    int bad   = 0;

    masked_round_state_reg #(.WIDTH(8), .SHARES(2), .ROUNDS(3), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .D0(d0), .D1(d1),
        .Q(q), .round(round), .stage(stage), .busy(busy), .done(done)
    );

    masked_round_state_reg #(.WIDTH(8), .SHARES(2), .ROUNDS(5), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst2), .start(start2), .D0(d0_2), .D1(d1_2),
        .Q(q2), .round(round2), .stage(stage2), .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst2 = 1'b1; start = 1'b0; start2 = 1'b0;
        d0 = 16'h0000; d1 = 16'h0000; d0_2 = 16'h0000; d1_2 = 16'h0000;
        step(); step();
        rst = 1'b0; rst2 = 1'b0;
        total++; if (q !== 16'h0000) begin bad++; $display("FAIL reset_q got=%h exp=0000", q); end
        total++; if (round !== 2'd0) begin bad++; $display("FAIL reset_round got=%0d exp=0", round); end
        total++; if (stage !== 2'd0) begin bad++; $display("FAIL reset_stage got=%0d exp=0", stage); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_flags busy=%b done=%b exp=0/0", busy, done); end
        total++; if (q2 !== 16'h0000 || busy2 !== 1'b0 || round2 !== 3'd0) begin bad++; $display("FAIL reset_dut1 q=%h busy=%b round=%0d exp=0000/0/0", q2, busy2, round2); end
        step();
        total++; if (q !== 16'h0000 || busy !== 1'b0) begin bad++; $display("FAIL idle_hold q=%h busy=%b exp=0000/0", q, busy); end
    endtask

    // Basic run with per-round D1 values and an ignored start at t+5.
    task automatic test_basic();
        logic [15:0] vals [3];
        int busy_cnt;
        vals[0] = 16'h1234; vals[1] = 16'h5678; vals[2] = 16'h9ABC;
        busy_cnt = 0;
        d0 = 16'hA55A; d1 = vals[0]; start = 1'b1;
        step();
        start = 1'b0;
        total++; if (q !== 16'hA55A) begin bad++; $display("FAIL basic_load got=%h exp=a55a", q); end
        total++; if (busy !== 1'b1 || round !== 2'd0 || stage !== 2'd0) begin bad++; $display("FAIL basic_start busy=%b round=%0d stage=%0d exp=1/0/0", busy, round, stage); end
        if (busy) busy_cnt++;
        for (int k = 1; k <= 13; k++) begin
            logic [15:0] exp_q;
            d1 = vals[((k - 1) / 4) % 3];
            if (k == 5) begin start = 1'b1; d0 = 16'h0F0F; end
            else start = 1'b0;
            step();
            exp_q = (k < 4) ? 16'hA55A : vals[((k < 13 ? k : 12) / 4) - 1];
            if (busy) busy_cnt++;
            total++; if (q !== exp_q) begin bad++; $display("FAIL basic_q k=%0d got=%h exp=%h", k, q, exp_q); end
            total++; if (round !== 2'((k < 13 ? k : 12) / 4)) begin bad++; $display("FAIL basic_round k=%0d got=%0d exp=%0d", k, round, (k < 13 ? k : 12) / 4); end
            total++; if (stage !== 2'(k % 4) && k < 13) begin bad++; $display("FAIL basic_stage k=%0d got=%0d exp=%0d", k, stage, k % 4); end
            total++; if (done !== (k == 12)) begin bad++; $display("FAIL basic_done k=%0d got=%b exp=%b", k, done, (k == 12)); end
            total++; if (busy !== (k < 12)) begin bad++; $display("FAIL basic_busy k=%0d got=%b exp=%b", k, busy, (k < 12)); end
        end
        total++; if (busy_cnt != 12) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=12", busy_cnt); end
    endtask

    task automatic test_reset_mid();
        int done_cnt;
        done_cnt = 0;
        d0 = 16'h3C3C; d1 = 16'h7777; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 5; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (q !== 16'h0000) begin bad++; $display("FAIL rstmid_q got=%h exp=0000", q); end
        total++; if (round !== 2'd0 || stage !== 2'd0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_ctl round=%0d stage=%0d busy=%b exp=0/0/0", round, stage, busy); end
        for (int k = 0; k < 12; k++) begin
            if (done) done_cnt++;
            step();
        end
        total++; if (done_cnt != 0) begin bad++; $display("FAIL rstmid_done got=%0d pulses exp=0", done_cnt); end
    endtask

    task automatic test_back_to_back();
        int gap;
        gap = 0;
        d0 = 16'h1111; d1 = 16'h2222; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 11; k++) step();
        start = 1'b1; d0 = 16'hC3C3;
        step();
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL b2b_done1 done=%b busy=%b exp=1/0", done, busy); end
        step();
        start = 1'b0;
        total++; if (q !== 16'hC3C3) begin bad++; $display("FAIL b2b_reload got=%h exp=c3c3", q); end
        total++; if (busy !== 1'b1 || done !== 1'b0 || round !== 2'd0) begin bad++; $display("FAIL b2b_restart busy=%b done=%b round=%0d exp=1/0/0", busy, done, round); end
        for (int j = 1; j <= 30; j++) begin
            step();
            if (done) begin gap = j; break; end
        end
        total++; if (gap != 12) begin bad++; $display("FAIL b2b_done2 gap=%0d exp=12", gap); end
        step();
    endtask

    task automatic test_share_isolation();
        d0 = 16'h0000; d1 = 16'h00FF; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) step();
        total++; if (q[7:0] !== 8'hFF || q[15:8] !== 8'h00) begin bad++; $display("FAIL iso_cap1 got=%h exp=00ff", q); end
        d1 = 16'h00EF;
        for (int k = 5; k <= 8; k++) step();
        total++; if (q[15:8] !== 8'h00 || q[7:0] !== 8'hEF) begin bad++; $display("FAIL iso_tog0 got=%h exp=00ef", q); end
        d1 = 16'h01FF;
        for (int k = 9; k <= 12; k++) step();
        total++; if (q[7:0] !== 8'hFF || q[15:8] !== 8'h01) begin bad++; $display("FAIL iso_tog1 got=%h exp=01ff", q); end
        step();
    endtask

    task automatic test_stages1();
        logic [15:0] vals [5];
        int busy_cnt;
        vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
        vals[3] = 16'h4444; vals[4] = 16'h5555;
        busy_cnt = 0;
        d0_2 = 16'h0102; start2 = 1'b1;
        step();
        start2 = 1'b0;
        total++; if (q2 !== 16'h0102 || busy2 !== 1'b1) begin bad++; $display("FAIL s1_load q=%h busy=%b exp=0102/1", q2, busy2); end
        if (busy2) busy_cnt++;
        for (int k = 1; k <= 5; k++) begin
            d1_2 = vals[k - 1];
            step();
            if (busy2) busy_cnt++;
            total++; if (q2 !== vals[k - 1]) begin bad++; $display("FAIL s1_q k=%0d got=%h exp=%h", k, q2, vals[k - 1]); end
            total++; if (round2 !== 3'(k) || stage2 !== 1'b0) begin bad++; $display("FAIL s1_ctl k=%0d round=%0d stage=%0d exp=%0d/0", k, round2, stage2, k); end
            total++; if (done2 !== (k == 5)) begin bad++; $display("FAIL s1_done k=%0d got=%b exp=%b", k, done2, (k == 5)); end
        end
        total++; if (busy_cnt != 5) begin bad++; $display("FAIL s1_busy_cycles got=%0d exp=5", busy_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reset_mid();
        test_back_to_back();
        test_share_isolation();
        test_stages1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
